// File: rtl/branch_resolve_if.sv
// Branch-resolve bus: operands, mode, prediction and pipeline controls in; registered outcome out.
// BR_CNT/MP_CNT exist only when BRRES_PERF_CNT_EN is defined.
interface branch_resolve_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic             IN_VALID;
    logic [WIDTH-1:0] RFMUX1;
    logic [WIDTH-1:0] RFMUX2;
    logic [2:0]       MODE;
    logic             PRED_TAKEN;
    logic             STALL;
    logic             FLUSH;
    logic             CNT_CLR;
    logic             OUT_VALID;
    logic             EQ;
    logic             TAKEN;
    logic             MISPRED;
`ifdef BRRES_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] BR_CNT;
    logic [CNT_WIDTH-1:0] MP_CNT;
`else
    localparam int UNUSED_CNT_WIDTH = CNT_WIDTH;
`endif

    // Valid/ready note: there is no ready; IN_VALID is sampled every unstalled cycle,
    // and OUT_VALID qualifies TAKEN/MISPRED one cycle later.
    modport master (
        output IN_VALID, RFMUX1, RFMUX2, MODE, PRED_TAKEN, STALL, FLUSH, CNT_CLR,
        input  OUT_VALID, EQ, TAKEN, MISPRED
`ifdef BRRES_PERF_CNT_EN
        , input BR_CNT, MP_CNT
`endif
    );

    modport slave (
        input  IN_VALID, RFMUX1, RFMUX2, MODE, PRED_TAKEN, STALL, FLUSH, CNT_CLR,
        output OUT_VALID, EQ, TAKEN, MISPRED
`ifdef BRRES_PERF_CNT_EN
        , output BR_CNT, MP_CNT
`endif
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch compare/resolve stage: one-cycle registered outcome and mispredict flag.
// Optional saturating performance counters are built when BRRES_PERF_CNT_EN is defined.
module branch_resolve #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input logic              CLK,
    input logic              RST_N,
    branch_resolve_if.slave  bus
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;
    logic w_taken;
    logic w_mis;
    logic w_load;

    logic r_out_valid;
    logic r_eq;
    logic r_taken;
    logic r_mispred;

    assign w_eq   = (bus.RFMUX1 == bus.RFMUX2);
    assign w_lt   = ($signed(bus.RFMUX1) < $signed(bus.RFMUX2));
    assign w_ltu  = (bus.RFMUX1 < bus.RFMUX2);
    assign w_mis  = w_taken ^ bus.PRED_TAKEN;
    assign w_load = bus.IN_VALID && !bus.STALL && !bus.FLUSH;

    // Reserved modes resolve not-taken, so their mispredict equals the prediction.
    always_comb begin
        w_taken = 1'b0;
        case (bus.MODE)
            3'd0:    w_taken = w_eq;
            3'd1:    w_taken = !w_eq;
            3'd2:    w_taken = w_lt;
            3'd3:    w_taken = !w_lt;
            3'd4:    w_taken = w_ltu;
            3'd5:    w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_eq        <= 1'b0;
            r_taken     <= 1'b0;
            r_mispred   <= 1'b0;
        end else if (bus.FLUSH) begin
            r_out_valid <= 1'b0;
            r_eq        <= w_eq;
            r_taken     <= 1'b0;
            r_mispred   <= 1'b0;
        end else if (!bus.STALL) begin
            r_out_valid <= bus.IN_VALID;
            r_eq        <= w_eq;
            r_taken     <= bus.IN_VALID && w_taken;
            r_mispred   <= bus.IN_VALID && w_mis;
        end
    end

    assign bus.OUT_VALID = r_out_valid;
    assign bus.EQ        = r_eq;
    assign bus.TAKEN     = r_taken;
    assign bus.MISPRED   = r_mispred;

`ifdef BRRES_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_br_cnt;
    logic [CNT_WIDTH-1:0] r_mp_cnt;

    // Clear wins over increment and is honoured during a stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (bus.CNT_CLR) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (w_load) begin
            if (r_br_cnt != '1)
                r_br_cnt <= r_br_cnt + 1'b1;
            if (w_mis && (r_mp_cnt != '1))
                r_mp_cnt <= r_mp_cnt + 1'b1;
        end
    end

    assign bus.BR_CNT = r_br_cnt;
    assign bus.MP_CNT = r_mp_cnt;
`else
    localparam int UNUSED_CNT_WIDTH = CNT_WIDTH;
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.CNT_CLR;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve (WIDTH=32, CNT_WIDTH=4); counter checks only when BRRES_PERF_CNT_EN is defined.
module tb_branch_resolve;
    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 4;

    logic CLK;
    logic RST_N;
    int   n_vectors;
    int   n_miscompares;

    branch_resolve_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    branch_resolve #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] mode, input logic pred);
        bus.IN_VALID   = v;
        bus.RFMUX1     = a;
        bus.RFMUX2     = b;
        bus.MODE       = mode;
        bus.PRED_TAKEN = pred;
    endtask

    task automatic ctrl(input logic stall, input logic flush, input logic clr);
        bus.STALL   = stall;
        bus.FLUSH   = flush;
        bus.CNT_CLR = clr;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic eq,
                              input logic tk, input logic mp);
        check({tag, ".ov"}, {63'd0, bus.OUT_VALID}, {63'd0, ov});
        check({tag, ".eq"}, {63'd0, bus.EQ},        {63'd0, eq});
        check({tag, ".tk"}, {63'd0, bus.TAKEN},     {63'd0, tk});
        check({tag, ".mp"}, {63'd0, bus.MISPRED},   {63'd0, mp});
    endtask

    task automatic expect_cnt(input string tag, input int br, input int mp);
`ifdef BRRES_PERF_CNT_EN
        check({tag, ".br_cnt"}, 64'(bus.BR_CNT), 64'(br));
        check({tag, ".mp_cnt"}, 64'(bus.MP_CNT), 64'(mp));
`else
        if (tag.len() == 0) $display("empty tag %0d %0d", br, mp);
`endif
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        RST_N = 1'b0;
        ctrl(1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 3'd0, 1'b0);
        #2;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cnt("reset", 0, 0);
        step();
        step();
        RST_N = 1'b1;

        // EQ, not predicted: taken and mispredicted
        drive(1'b1, 32'h1234, 32'h1234, 3'd0, 1'b0);
        step();
        expect_out("beq", 1'b1, 1'b1, 1'b1, 1'b1);
        expect_cnt("beq", 1, 1);

        drive(1'b1, 32'd5, 32'd7, 3'd1, 1'b1);
        step();
        expect_out("bne", 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cnt("bne", 2, 1);

        // signed vs unsigned with A=-1, B=1
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0);
        step();
        expect_out("blt", 1'b1, 1'b0, 1'b1, 1'b1);
        expect_cnt("blt", 3, 2);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0);
        step();
        expect_out("bltu", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cnt("bltu", 4, 2);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b1);
        step();
        expect_out("bgeu", 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cnt("bgeu", 5, 2);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0);
        step();
        expect_out("bge", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cnt("bge", 6, 2);

        // reserved mode: never taken, mispredict follows prediction
        drive(1'b1, 32'd9, 32'd9, 3'd6, 1'b1);
        step();
        expect_out("rsv6", 1'b1, 1'b1, 1'b0, 1'b1);
        expect_cnt("rsv6", 7, 3);
        drive(1'b1, 32'd9, 32'd8, 3'd7, 1'b0);
        step();
        expect_out("rsv7", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cnt("rsv7", 8, 3);

        // idle: EQ still tracks operands
        drive(1'b0, 32'd3, 32'd3, 3'd1, 1'b1);
        step();
        expect_out("idle", 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cnt("idle", 8, 3);

        // stall freezes, then flush squashes
        drive(1'b1, 32'd2, 32'd2, 3'd0, 1'b1);
        step();
        expect_out("pre_stall", 1'b1, 1'b1, 1'b1, 1'b0);
        expect_cnt("pre_stall", 9, 3);
        drive(1'b1, 32'd1, 32'd2, 3'd0, 1'b1);
        ctrl(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
            expect_cnt($sformatf("stall%0d", i), 9, 3);
        end
        ctrl(1'b1, 1'b1, 1'b0);
        step();
        check("flush.ov", {63'd0, bus.OUT_VALID}, 64'd0);
        check("flush.tk", {63'd0, bus.TAKEN},     64'd0);
        check("flush.mp", {63'd0, bus.MISPRED},   64'd0);
        expect_cnt("flush", 9, 3);
        ctrl(1'b0, 1'b0, 1'b0);

        // saturation and clear
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        ctrl(1'b0, 1'b0, 1'b1);
        step();
        expect_cnt("clr", 0, 0);
        ctrl(1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd4, 32'd4, 3'd0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        expect_out("sat", 1'b1, 1'b1, 1'b1, 1'b1);
        expect_cnt("sat", 15, 15);
        ctrl(1'b0, 1'b0, 1'b1);
        step();
        expect_out("clr_vs_inc", 1'b1, 1'b1, 1'b1, 1'b1);
        expect_cnt("clr_vs_inc", 0, 0);
        ctrl(1'b0, 1'b0, 1'b0);
        step();
        expect_cnt("inc_after_clr", 1, 1);
        ctrl(1'b1, 1'b0, 1'b1);
        step();
        expect_cnt("clr_in_stall", 0, 0);
        ctrl(1'b0, 1'b0, 1'b0);

        // async reset between edges while a result is valid and another is in flight
        drive(1'b1, 32'd1, 32'd2, 3'd4, 1'b1);
        step();
        expect_out("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cnt("async_rst", 0, 0);
        step();
        expect_out("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cnt("in_rst", 0, 0);
        #3;
        RST_N = 1'b1;
        drive(1'b0, 32'd1, 32'd2, 3'd4, 1'b0);
        step();
        expect_out("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd1, 32'd2, 3'd4, 1'b0);
        step();
        expect_out("post_rst_first", 1'b1, 1'b0, 1'b1, 1'b1);
        expect_cnt("post_rst_first", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
